// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch redirects,
// mult/div sequencing with a bounded wait, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic [4:0]       fd_rs1_i,
    input  logic [4:0]       fd_rs2_i,
    input  logic             fd_uses_rs2_i,
    input  logic             dx_is_load_i,
    input  logic [4:0]       dx_rd_i,
    input  logic             branch_taken_i,
    input  logic             md_start_i,
    input  logic             md_is_div_i,
    input  logic             md_ready_i,
    output logic             pc_stall_o,
    output logic             fd_stall_o,
    output logic             fd_flush_o,
    output logic             dx_stall_o,
    output logic             dx_bubble_o,
    output logic             xm_bubble_o,
    output logic             ctrl_mult_o,
    output logic             ctrl_div_o,
    output logic             md_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic             state_o
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

    localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic                md_start_q;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic pc_stall, fd_stall, fd_flush, dx_stall, dx_bubble, xm_bubble, ctrl_mult, ctrl_div;
    logic md_rise;
    logic load_use;

    // The op stays in X (md_start held) after release, so only a rising edge re-arms.
    assign md_rise = md_start_i & ~md_start_q;

    assign load_use = dx_is_load_i && (dx_rd_i != 5'd0) &&
                      ((dx_rd_i == fd_rs1_i) || (fd_uses_rs2_i && (dx_rd_i == fd_rs2_i)));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        pc_stall   = 1'b0;
        fd_stall   = 1'b0;
        fd_flush   = 1'b0;
        dx_stall   = 1'b0;
        dx_bubble  = 1'b0;
        xm_bubble  = 1'b0;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (md_rise) begin
                    ctrl_mult  = ~md_is_div_i;
                    ctrl_div   = md_is_div_i;
                    pc_stall   = 1'b1;
                    fd_stall   = 1'b1;
                    dx_stall   = 1'b1;
                    xm_bubble  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_MD_WAIT;
                end else if (branch_taken_i) begin
                    fd_flush  = 1'b1;
                    dx_bubble = 1'b1;
                end else if (load_use) begin
                    pc_stall  = 1'b1;
                    fd_stall  = 1'b1;
                    dx_bubble = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (md_ready_i) begin
                    // Stalls drop in the ready cycle so X/M captures the result at this edge.
                    state_d = ST_RUN;
                end else begin
                    pc_stall  = 1'b1;
                    fd_stall  = 1'b1;
                    dx_stall  = 1'b1;
                    xm_bubble = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign pc_stall_o   = reset_ni & pc_stall;
    assign fd_stall_o   = reset_ni & fd_stall;
    assign fd_flush_o   = reset_ni & fd_flush;
    assign dx_stall_o   = reset_ni & dx_stall;
    assign dx_bubble_o  = reset_ni & dx_bubble;
    assign xm_bubble_o  = reset_ni & xm_bubble;
    assign ctrl_mult_o  = reset_ni & ctrl_mult;
    assign ctrl_div_o   = reset_ni & ctrl_div;
    assign md_timeout_o = timeout_q;
    assign stall_cycles_o = stall_cnt_q;
    assign state_o      = state_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            md_start_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            md_start_q  <= md_start_i;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
